// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - alu_mc op codes, alu_ctl field positions, FSM and shift-mode types
package alu_mc_pkg;

  // alu_ctl[3:0] operation codes
  localparam logic [3:0] ALUCTL_3to0_AND   = 4'b0000;
  localparam logic [3:0] ALUCTL_3to0_OR    = 4'b0001;
  localparam logic [3:0] ALUCTL_3to0_ADD   = 4'b0010;
  localparam logic [3:0] ALUCTL_3to0_SRL   = 4'b0011;
  localparam logic [3:0] ALUCTL_3to0_SRA   = 4'b0100;
  localparam logic [3:0] ALUCTL_3to0_SLL   = 4'b0101;
  localparam logic [3:0] ALUCTL_3to0_SUB   = 4'b0110;
  localparam logic [3:0] ALUCTL_3to0_SLT   = 4'b0111;
  localparam logic [3:0] ALUCTL_3to0_XOR   = 4'b1000;
  localparam logic [3:0] ALUCTL_3to0_CSRRW = 4'b1001;
  localparam logic [3:0] ALUCTL_3to0_CSRRS = 4'b1010;
  localparam logic [3:0] ALUCTL_3to0_CSRRC = 4'b1011;
  localparam logic [3:0] ALUCTL_3to0_SLTU  = 4'b1100;

  // alu_ctl branch-control bit indices
  localparam int ALUCTL_6 = 6;  // 0: equality, 1: less-than
  localparam int ALUCTL_5 = 5;  // less-than is unsigned
  localparam int ALUCTL_4 = 4;  // invert the branch condition

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SRL = 2'd0,
    SH_SRA = 2'd1,
    SH_SLL = 2'd2
  } sh_mode_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALUCTL_3to0_SRL) || (op == ALUCTL_3to0_SRA) || (op == ALUCTL_3to0_SLL);
  endfunction

endpackage

// File: rtl/alu_mc_shifter.sv
// rtl/alu_mc_shifter.sv - iterative shifter, SHIFT_STEP bits per cycle with remaining-count down-counter
module alu_mc_shifter
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int SHIFT_STEP = 4,
  localparam int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  sh_mode_e         mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHW:0] STEP_L = SHIFT_STEP[SHW:0];

  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   rem_q;
  sh_mode_e         mode_q;
  logic             busy_q;

  logic [SHW:0]     rem_ext;
  logic             last_step;
  logic [SHW:0]     amt;
  logic [WIDTH-1:0] shifted;

  // Step size is min(SHIFT_STEP, remaining); the final step finishes the op
  always_comb begin
    rem_ext   = {1'b0, rem_q};
    last_step = (rem_ext <= STEP_L);
    amt       = last_step ? rem_ext : STEP_L;
    shifted   = data_q;
    case (mode_q)
      SH_SRL:  shifted = data_q >> amt;
      SH_SRA:  shifted = $unsigned($signed(data_q) >>> amt);
      SH_SLL:  shifted = data_q << amt;
      default: shifted = data_q;
    endcase
    done   = busy_q && last_step;
    result = shifted;
  end

  // Load on start (caller guarantees shamt > 0), then one step per cycle until done or abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      rem_q  <= '0;
      mode_q <= SH_SRL;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      data_q <= data;
      rem_q  <= shamt;
      mode_q <= mode;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      data_q <= shifted;
      rem_q  <= rem_q - amt[SHW-1:0];
      if (last_step) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshakes, flush and iterative shifts
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int SHIFT_STEP = 4,
  localparam int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_en
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;

  logic [3:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] diff;
  logic             lt_u, lt_s, ovf;
  logic             illegal_op;
  logic [WIDTH-1:0] quick_res;
  logic             branch_new;
  logic             need_shift;
  sh_mode_e         sh_mode;
  logic             accept;
  logic             sh_start, sh_done;
  logic [WIDTH-1:0] sh_result;

  // Single-cycle datapath and branch decision on the presented operands
  always_comb begin
    op         = alu_ctl[3:0];
    shamt      = b[SHW-1:0];
    sub_ext    = {1'b0, a} - {1'b0, b};
    diff       = sub_ext[WIDTH-1:0];
    lt_u       = sub_ext[WIDTH];
    ovf        = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    lt_s       = diff[WIDTH-1] ^ ovf;
    illegal_op = (op >= 4'b1101);
    quick_res  = '0;
    case (op)
      ALUCTL_3to0_AND:   quick_res = a & b;
      ALUCTL_3to0_OR:    quick_res = a | b;
      ALUCTL_3to0_ADD:   quick_res = a + b;
      ALUCTL_3to0_SUB:   quick_res = diff;
      ALUCTL_3to0_SLT:   quick_res = {{(WIDTH-1){1'b0}}, lt_s};
      ALUCTL_3to0_XOR:   quick_res = a ^ b;
      ALUCTL_3to0_CSRRW: quick_res = a;
      ALUCTL_3to0_CSRRS: quick_res = a | b;
      ALUCTL_3to0_CSRRC: quick_res = ~a & b;
      ALUCTL_3to0_SLTU:  quick_res = {{(WIDTH-1){1'b0}}, lt_u};
      // zero-distance shifts complete here with the operand unchanged
      ALUCTL_3to0_SRL,
      ALUCTL_3to0_SRA,
      ALUCTL_3to0_SLL:   quick_res = a;
      default:           quick_res = '0;
    endcase
    if (illegal_op) begin
      branch_new = 1'b0;
    end else if (alu_ctl[ALUCTL_6]) begin
      branch_new = (alu_ctl[ALUCTL_5] ? lt_u : lt_s) ^ alu_ctl[ALUCTL_4];
    end else begin
      branch_new = (a == b) ^ alu_ctl[ALUCTL_4];
    end
    need_shift = is_shift_op(op) && (shamt != '0);
    case (op)
      ALUCTL_3to0_SRA: sh_mode = SH_SRA;
      ALUCTL_3to0_SLL: sh_mode = SH_SLL;
      default:         sh_mode = SH_SRL;
    endcase
  end

  // Handshake and next-state logic; flush overrides everything except reset
  always_comb begin
    in_ready = rst_n && !flush &&
               ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    accept   = in_valid && in_ready;
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    sh_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          branch_d = branch_new;
          if (need_shift) begin
            state_d  = S_SHIFT;
            sh_start = 1'b1;
          end else begin
            state_d  = S_DONE;
            result_d = quick_res;
          end
        end
      end
      S_SHIFT: begin
        if (sh_done) begin
          state_d  = S_DONE;
          result_d = sh_result;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (accept) begin
            branch_d = branch_new;
            if (need_shift) begin
              state_d  = S_SHIFT;
              sh_start = 1'b1;
            end else begin
              state_d  = S_DONE;
              result_d = quick_res;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      branch_d = branch_q;
      sh_start = 1'b0;
    end
  end

  // State, result and branch registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

  alu_mc_shifter #(
    .WIDTH     (WIDTH),
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (flush),
    .start (sh_start),
    .mode  (sh_mode),
    .shamt (shamt),
    .data  (a),
    .done  (sh_done),
    .result(sh_result)
  );

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign branch_en = branch_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - table-driven and scoreboard bench for alu_mc
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  alu_ctl;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_en;

  logic        flush8;
  logic        in_valid8;
  logic        in_ready8;
  logic [6:0]  alu_ctl8;
  logic [7:0]  a8, b8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic        branch_en8;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .SHIFT_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_en(branch_en)
  );

  alu_mc #(.WIDTH(8), .SHIFT_STEP(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_ctl(alu_ctl8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .branch_en(branch_en8)
  );

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
  } exp_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every result handed over is matched against the oldest expectation
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got result %h with empty scoreboard", result);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("out%0d_result", mon_idx), result, mon_e.res);
        chk($sformatf("out%0d_branch", mon_idx), {31'd0, branch_en}, {31'd0, mon_e.br});
        mon_idx++;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance
  task automatic send(input logic [6:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] er, input logic eb);
    int t;
    alu_ctl  = ctl;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for ctl %h", ctl);
    end else begin
      sb_q.push_back('{res: er, br: eb});
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Starts on the falling edge right after acceptance; accept-to-out_valid in cycles
  task automatic lat_check(input string nm, input int exp_lat);
    int lat;
    lat = 1;
    #1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk(nm, lat, exp_lat);
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(nm, sb_q.size(), 0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{7'h02, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[1]  = '{7'h0C, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[2]  = '{7'h16, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1};
    vecs[3]  = '{7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[4]  = '{7'h01, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
    vecs[5]  = '{7'h08, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0};
    vecs[6]  = '{7'h47, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1};
    vecs[7]  = '{7'h47, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[8]  = '{7'h6C, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b1};
    vecs[9]  = '{7'h09, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{7'h0A, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0};
    vecs[11] = '{7'h0B, 32'h0000FFFF, 32'h12345678, 32'h12340000, 1'b0};
    vecs[12] = '{7'h0D, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[13] = '{7'h02, 32'h00000003, 32'h00000003, 32'h00000006, 1'b1};
    vecs[14] = '{7'h05, 32'h1234ABCD, 32'h00000000, 32'h1234ABCD, 1'b0};
    vecs[15] = '{7'h04, 32'h80000000, 32'h0000000D, 32'hFFFC0000, 1'b0};
    vecs[16] = '{7'h03, 32'h80000000, 32'h0000000D, 32'h00040000, 1'b0};
    vecs[17] = '{7'h05, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    vecs[18] = '{7'h05, 32'h000000FF, 32'h00000024, 32'h00000FF0, 1'b0};
    vecs[19] = '{7'h04, 32'h70000000, 32'h00000003, 32'h0E000000, 1'b0};
    vecs[20] = '{7'h7C, 32'h00000009, 32'h00000009, 32'h00000000, 1'b1};
    vecs[21] = '{7'h04, 32'h80000000, 32'h00000008, 32'hFF800000, 1'b0};
    vecs[22] = '{7'h04, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0};
    vecs[23] = '{7'h03, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_ctl = '0; a = '0; b = '0; out_ready = 1'b1;
    flush8 = 1'b0; in_valid8 = 1'b0; alu_ctl8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_branch", {31'd0, branch_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // vector table, back to back with out_ready held high
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].br);
    end
    drain("table_drain");

    // latencies
    send(7'h02, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
    lat_check("lat_add", 1);
    send(7'h04, 32'h80000000, 32'd13, 32'hFFFC0000, 1'b0);
    lat_check("lat_sra13", 5);
    send(7'h05, 32'h00C0FFEE, 32'd0, 32'h00C0FFEE, 1'b0);
    lat_check("lat_sll0", 1);
    drain("lat_drain");

    // backpressure: result held, then hand-over and new accept on one edge
    out_ready = 1'b0;
    send(7'h08, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_result", k), result, 32'hFF00FF00);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    alu_ctl = 7'h02; a = 32'd2; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    sb_q.push_back('{res: 32'd5, br: 1'b0});
    #1;
    chk("bp_same_edge_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_new_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_new_result", result, 32'd5);
    @(negedge clk);
    drain("bp_drain");

    // flush during a long SLL
    send(7'h02, 32'd10, 32'd20, 32'd30, 1'b0);
    send(7'h05, 32'h1, 32'd31, 32'h80000000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_result_hold", result, 32'd30);
    sb_q.delete(sb_q.size() - 1);
    @(negedge clk);
    send(7'h02, 32'd2, 32'd3, 32'd5, 1'b0);
    drain("flush_drain");

    // one-cycle reset in the middle of an SRL whose branch decision is 1
    send(7'h13, 32'hF0000000, 32'd20, 32'h00000F00, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_branch", {31'd0, branch_en}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    sb_q.delete(sb_q.size() - 1);
    @(negedge clk);
    send(7'h02, 32'd1, 32'd1, 32'd2, 1'b1);
    drain("midrst_drain");

    // WIDTH=8, SHIFT_STEP=1: SRL 0x80 by 7
    alu_ctl8 = 7'h03; a8 = 8'h80; b8 = 8'd7; in_valid8 = 1'b1;
    #1;
    chk("w8_in_ready", {31'd0, in_ready8}, 32'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    #1;
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("w8_srl_latency", lat, 8);
    chk("w8_srl_result", {24'd0, result8}, 32'h01);
    chk("w8_srl_branch", {31'd0, branch_en8}, 32'd0);
    @(negedge clk);
    alu_ctl8 = 7'h02; a8 = 8'hFF; b8 = 8'h01; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    chk("w8_add_valid", {31'd0, out_valid8}, 32'd1);
    chk("w8_add_result", {24'd0, result8}, 32'h00);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
